// File: rtl/fc_pkg.sv
// Shared types and width helpers for the fully-connected spike scheduler.
package fc_pkg;

  // Scheduler states, one per phase of a time step.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_ACCUM = 3'd2,
    S_ACTIV = 3'd3,
    S_FIRE  = 3'd4,
    S_CAPT  = 3'd5,
    S_OUT   = 3'd6
  } sched_state_t;

  // Total number of spike positions in one input frame.
  function automatic int frame_w(input int in_channels, input int frame_size);
    return in_channels * frame_size;
  endfunction

  // Address width for a frame; never below one bit.
  function automatic int addr_w(input int fw);
    return (fw > 1) ? $clog2(fw) : 1;
  endfunction

endpackage

// File: rtl/spk_prio_enc.sv
// Lowest-set-bit encoder over the pending spike mask.
module spk_prio_enc #(
  parameter int W  = 56,
  parameter int AW = 6
) (
  input  logic [W-1:0]  vec,
  output logic [AW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set index is the one left standing.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = AW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fc_spk_sched.sv
// Per-time-step event scheduler for a bank of fully-connected neuron cores.
// Takes one input spike frame, broadcasts its spike addresses in ascending
// order, triggers activation, then collects the cores' output spikes.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is only high in IDLE; out_valid is only high in OUT and
// out_spk/out_last stay stable there until out_ready is seen.
module fc_spk_sched
  import fc_pkg::*;
#(
  parameter  int IN_CHANNELS      = 2,
  parameter  int INPUT_FRAME_SIZE = 28,
  parameter  int LAYER_SIZE       = 10,
  parameter  int NUM_TIME_STEPS   = 25,
  localparam int FRAME_W          = frame_w(IN_CHANNELS, INPUT_FRAME_SIZE),
  localparam int AW               = addr_w(FRAME_W),
  localparam int TSW              = (NUM_TIME_STEPS > 1) ? $clog2(NUM_TIME_STEPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_W-1:0]    in_spk,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  en_accum,
  output logic                  en_activ,
  output logic [AW-1:0]         spk_addr,
  output logic                  last_time_step,
  input  logic [LAYER_SIZE-1:0] nc_spk,
  output logic [LAYER_SIZE-1:0] out_spk,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [AW:0]           frame_spk_cnt,
  output logic [2:0]            dbg_state,
  output logic [TSW-1:0]        dbg_ts_cnt
);

  localparam logic [TSW-1:0] TS_LAST = TSW'(NUM_TIME_STEPS - 1);

  sched_state_t       state;
  logic [FRAME_W-1:0] mask;
  logic [TSW-1:0]     ts_cnt;
  logic [AW-1:0]      enc_idx;
  logic               enc_any;
  logic [AW:0]        in_popcnt;
  logic [FRAME_W-1:0] clr_bit;

  spk_prio_enc #(
    .W  (FRAME_W),
    .AW (AW)
  ) u_enc (
    .vec (mask),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Count the spikes of the incoming frame so the count is ready at accept.
  always_comb begin
    in_popcnt = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      in_popcnt = in_popcnt + (AW + 1)'(in_spk[i]);
    end
  end

  // One-hot of the address being emitted, used to retire it from the mask.
  always_comb begin
    clr_bit = FRAME_W'(1) << enc_idx;
  end

  // Control strobes are decoded from the state register alone, so they are
  // mutually exclusive by construction.
  assign in_ready       = (state == S_IDLE);
  assign en_accum       = (state == S_ARM);
  assign en_activ       = (state == S_ACTIV);
  assign out_valid      = (state == S_OUT);
  assign last_time_step = (ts_cnt == TS_LAST);
  assign dbg_state      = state;
  assign dbg_ts_cnt     = ts_cnt;

  // Main scheduler FSM. The first address is loaded while in ARM so that
  // spk_addr is already valid on the first ACCUM cycle; each ACCUM cycle
  // then preloads the next one, and the last value is held through ACTIV.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      mask          <= '0;
      ts_cnt        <= '0;
      frame_spk_cnt <= '0;
      spk_addr      <= '0;
      out_spk       <= '0;
      out_last      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mask          <= in_spk;
            frame_spk_cnt <= in_popcnt;
            state         <= S_ARM;
          end
        end
        S_ARM, S_ACCUM: begin
          if (enc_any) begin
            spk_addr <= enc_idx;
            mask     <= mask & ~clr_bit;
            state    <= S_ACCUM;
          end else begin
            state <= S_ACTIV;
          end
        end
        S_ACTIV: state <= S_FIRE;
        S_FIRE:  state <= S_CAPT;
        S_CAPT: begin
          out_spk  <= nc_spk;
          out_last <= last_time_step;
          state    <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            ts_cnt <= (ts_cnt == TS_LAST) ? '0 : ts_cnt + TSW'(1);
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_spk_sched.sv
// Directed bench for fc_spk_sched with a 2x28 frame, 10 cores, 3 time steps.
module tb_fc_spk_sched;
  import fc_pkg::*;

  localparam int FW  = 56;
  localparam int AW  = 6;
  localparam int LS  = 10;
  localparam int NTS = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [FW-1:0] in_spk    = '0;
  logic          in_valid  = 1'b0;
  logic [LS-1:0] nc_spk    = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, en_accum, en_activ, last_time_step, out_valid, out_last;
  logic [AW-1:0] spk_addr;
  logic [LS-1:0] out_spk;
  logic [AW:0]   frame_spk_cnt;
  logic [2:0]    dbg_state;
  logic [1:0]    dbg_ts_cnt;

  fc_spk_sched #(
    .IN_CHANNELS      (2),
    .INPUT_FRAME_SIZE (28),
    .LAYER_SIZE       (LS),
    .NUM_TIME_STEPS   (NTS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_spk         (in_spk),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .en_accum       (en_accum),
    .en_activ       (en_activ),
    .spk_addr       (spk_addr),
    .last_time_step (last_time_step),
    .nc_spk         (nc_spk),
    .out_spk        (out_spk),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .frame_spk_cnt  (frame_spk_cnt),
    .dbg_state      (dbg_state),
    .dbg_ts_cnt     (dbg_ts_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; all sampling and driving happens 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver for one full time step with cycle-exact checks. stall = cycles
  // out_ready is held low in OUT (with a competing in_valid offered).
  task automatic do_frame(input logic [FW-1:0] frame, input logic [LS-1:0] nc,
                          input logic exp_last, input int stall, input string tag);
    int n;
    logic [AW:0] exp_cnt;
    exp_q.delete();
    for (int i = 0; i < FW; i++) if (frame[i]) exp_q.push_back(AW'(i));
    n = exp_q.size();
    exp_cnt = (AW + 1)'(n);
    // cycle 0: handshake
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready c0: got %b exp 1", tag, in_ready); end
    n_checks++; if (last_time_step !== exp_last) begin n_fail++; $display("FAIL %s last_ts c0: got %b exp %b", tag, last_time_step, exp_last); end
    in_spk = frame; in_valid = 1'b1; nc_spk = nc;
    step();
    // cycle 1: ARM
    in_valid = 1'b0;
    in_spk = FW'({$urandom(), $urandom()});
    n_checks++; if (en_accum !== 1'b1) begin n_fail++; $display("FAIL %s en_accum c1: got %b exp 1", tag, en_accum); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s in_ready c1: got %b exp 0", tag, in_ready); end
    n_checks++; if (frame_spk_cnt !== exp_cnt) begin n_fail++; $display("FAIL %s frame_spk_cnt: got %0d exp %0d", tag, frame_spk_cnt, exp_cnt); end
    // cycles 2..N+1: ACCUM
    for (int k = 0; k < n; k++) begin
      step();
      n_checks++; if (spk_addr !== exp_q[k]) begin n_fail++; $display("FAIL %s spk_addr[%0d]: got %0d exp %0d", tag, k, spk_addr, exp_q[k]); end
      n_checks++; if (en_accum !== 1'b0 || en_activ !== 1'b0) begin n_fail++; $display("FAIL %s strobes in accum[%0d]: got accum=%b activ=%b exp 0 0", tag, k, en_accum, en_activ); end
    end
    // N+2: ACTIV
    step();
    n_checks++; if (en_activ !== 1'b1) begin n_fail++; $display("FAIL %s en_activ: got %b exp 1", tag, en_activ); end
    if (n > 0) begin
      n_checks++; if (spk_addr !== exp_q[n-1]) begin n_fail++; $display("FAIL %s spk_addr hold: got %0d exp %0d", tag, spk_addr, exp_q[n-1]); end
    end
    // N+3: FIRE
    step();
    n_checks++; if (en_activ !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL %s fire: got activ=%b ovalid=%b exp 0 0", tag, en_activ, out_valid); end
    // N+4: CAPT
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s ovalid capt: got %b exp 0", tag, out_valid); end
    n_checks++; if (last_time_step !== exp_last) begin n_fail++; $display("FAIL %s last_ts capt: got %b exp %b", tag, last_time_step, exp_last); end
    // N+5: OUT
    step();
    nc_spk = ~nc;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s out_valid: got %b exp 1", tag, out_valid); end
    n_checks++; if (out_spk !== nc) begin n_fail++; $display("FAIL %s out_spk: got %h exp %h", tag, out_spk, nc); end
    n_checks++; if (out_last !== exp_last) begin n_fail++; $display("FAIL %s out_last: got %b exp %b", tag, out_last, exp_last); end
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; in_spk = frame;
      step();
      n_checks++; if (out_valid !== 1'b1 || out_spk !== nc) begin n_fail++; $display("FAIL %s stall[%0d] out: got v=%b spk=%h exp 1 %h", tag, s, out_valid, out_spk, nc); end
      n_checks++; if (in_ready !== 1'b0 || en_accum !== 1'b0) begin n_fail++; $display("FAIL %s stall[%0d] accept: got ready=%b accum=%b exp 0 0", tag, s, in_ready, en_accum); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || en_accum !== 1'b0) begin n_fail++; $display("FAIL %s post-handshake: got v=%b ready=%b accum=%b exp 0 1 0", tag, out_valid, in_ready, en_accum); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    n_checks++; if (in_ready !== 1'b1 || en_accum !== 1'b0 || en_activ !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset strobes: got r=%b a=%b t=%b v=%b exp 1 0 0 0", in_ready, en_accum, en_activ, out_valid); end
    n_checks++; if (spk_addr !== '0 || out_spk !== '0 || out_last !== 1'b0 || frame_spk_cnt !== '0) begin n_fail++; $display("FAIL reset data: got addr=%0d spk=%h last=%b cnt=%0d exp 0", spk_addr, out_spk, out_last, frame_spk_cnt); end
    n_checks++; if (dbg_state !== S_IDLE || dbg_ts_cnt !== 2'd0) begin n_fail++; $display("FAIL reset state: got st=%0d ts=%0d exp 0 0", dbg_state, dbg_ts_cnt); end
    @(negedge clk); rst = 1'b1;
    step();
  endtask

  task automatic test_zero_frame();
    do_frame('0, 10'h2A5, 1'b0, 0, "zero");
  endtask

  task automatic test_sparse_frame();
    logic [FW-1:0] f;
    f = '0; f[55] = 1'b1; f[3] = 1'b1; f[17] = 1'b1;
    do_frame(f, 10'h13C, 1'b0, 0, "sparse");
  endtask

  task automatic test_all_ones();
    do_frame('1, 10'h3FF, 1'b1, 0, "all_ones");
  endtask

  task automatic test_wrap();
    logic [FW-1:0] f;
    f = '0; f[0] = 1'b1; f[28] = 1'b1;
    do_frame(f, 10'h001, 1'b0, 0, "wrap");
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] f;
    f = '0; f[9] = 1'b1; f[40] = 1'b1;
    do_frame(f, LS'($urandom_range(1, 1022)), 1'b0, 10, "backpressure");
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 10; i <= 20; i++) f[i] = 1'b1;
    in_spk = f; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_checks++; if (spk_addr !== 6'd11) begin n_fail++; $display("FAIL mid spk_addr pre-reset: got %0d exp 11", spk_addr); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || en_accum !== 1'b0 || en_activ !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid-reset strobes: got r=%b a=%b t=%b v=%b exp 1 0 0 0", in_ready, en_accum, en_activ, out_valid); end
    n_checks++; if (spk_addr !== '0 || out_spk !== '0 || out_last !== 1'b0 || frame_spk_cnt !== '0) begin n_fail++; $display("FAIL mid-reset data: got addr=%0d spk=%h last=%b cnt=%0d exp 0", spk_addr, out_spk, out_last, frame_spk_cnt); end
    n_checks++; if (dbg_ts_cnt !== 2'd0 || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL mid-reset state: got st=%0d ts=%0d exp 0 0", dbg_state, dbg_ts_cnt); end
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++; if (out_valid !== 1'b0 || en_activ !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL post-reset idle[%0d]: got v=%b activ=%b ready=%b exp 0 0 1", c, out_valid, en_activ, in_ready); end
    end
  endtask

  task automatic test_time_steps();
    logic [FW-1:0] f;
    f = '0; f[1] = 1'b1;
    do_frame(f, 10'h0F0, 1'b0, 0, "ts0");
    do_frame(f, 10'h00F, 1'b0, 0, "ts1");
    do_frame(f, 10'h300, 1'b1, 0, "ts2");
    do_frame(f, 10'h0C3, 1'b0, 0, "ts_wrap");
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_sparse_frame();
    test_all_ones();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_time_steps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_spk_sched.md
# fc_spk_sched

Event scheduler that sits directly upstream of the bank of fully-connected neuron cores (`LAYER_SIZE` instances, one per neuron), and drives their shared control inputs. Per time step it:
- accepts one binary input spike frame from the previous layer;
- scans the frame for set bits and broadcasts one presynaptic spike address per cycle;
- triggers the bias/threshold (activation) phase;
- collects the cores' `post_syn_spk` outputs into one output spike vector for the next layer.

It also counts time steps and flags the final step so the cores clear their membrane potentials.

## Interface
Parameters:
- `IN_CHANNELS`, 2: input channels of the layer.
- `INPUT_FRAME_SIZE`, 28: spike positions per channel. `FRAME_W = IN_CHANNELS*INPUT_FRAME_SIZE`, `AW = $clog2(FRAME_W)`.
- `LAYER_SIZE`, 10: number of neuron cores driven and collected.
- `NUM_TIME_STEPS`, 25: time steps per inference; must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_spk`  in  `FRAME_W`: input spike frame; bit i is spike address i.
- `in_valid`  in  1: `in_spk` is valid.
- `in_ready`  out  1: frame accepted on the cycle where `in_valid && in_ready`.
- `en_accum`  out  1: broadcast to all cores; starts accumulation.
- `en_activ`  out  1: broadcast; ends accumulation and starts the bias/threshold step.
- `spk_addr`  out  `AW`: broadcast presynaptic spike address.
- `last_time_step`  out  1: broadcast; high for the entire frame of step `NUM_TIME_STEPS-1`.
- `nc_spk`  in  `LAYER_SIZE`: `post_syn_spk` from core j on bit j.
- `out_spk`  out  `LAYER_SIZE`: captured output spike vector.
- `out_valid`  out  1: `out_spk` is valid.
- `out_ready`  in  1: downstream accepts on the cycle where `out_valid && out_ready`.
- `out_last`  out  1: `out_spk` belongs to the last time step.
- `frame_spk_cnt`  out  `AW+1`: number of input spikes in the current or last frame.

## Operation
- State machine: IDLE → ARM → ACCUM → ACTIV → FIRE → CAPT → OUT → IDLE.
- **IDLE**: `in_ready=1`. On handshake:
  - latch `in_spk` into the pending mask;
  - load `frame_spk_cnt` with the popcount of `in_spk`;
  - go to ARM.
- **ARM**: `en_accum=1` for exactly one cycle.
  - Mask non-zero → ACCUM.
  - Mask zero → ACTIV. No accumulation cycles; the frame still produces an activation.
- **ACCUM**: each cycle, drive `spk_addr` with the lowest set index of the pending mask and clear that bit.
  - Addresses are emitted in strictly ascending order.
  - After the last set bit has been emitted → ACTIV.
- **ACTIV**: `en_activ=1` for one cycle; `spk_addr` holds its last value.
- **FIRE**: one wait cycle while the cores evaluate their threshold.
- **CAPT**: register `nc_spk` into `out_spk`, set `out_last = last_time_step`, go to OUT.
- **OUT**: `out_valid=1`, with `out_spk` and `out_last` stable until the handshake.
  - On handshake: if `ts_cnt == NUM_TIME_STEPS-1`, wrap `ts_cnt` to 0; otherwise increment it.
  - Then go to IDLE.
- `last_time_step = (ts_cnt == NUM_TIME_STEPS-1)`.
  - Combinational from `ts_cnt`, so it is stable for the whole ARM…CAPT window.
  - With `NUM_TIME_STEPS=1`, it is permanently 1.
- `en_accum`, `en_activ`, `in_ready` and `out_valid` are mutually exclusive and are decoded from the state register only.

## Timing
- Reset (asynchronous assert, synchronous release) brings the block to:
  - state IDLE, `ts_cnt=0`, mask 0, `frame_spk_cnt=0`;
  - `out_spk=0`, `out_valid=0`, `out_last=0`;
  - `en_accum=0`, `en_activ=0`, `spk_addr=0`.
- Reset in any state abandons the frame; no partial output is produced. The cores are reset by their own `rst`.
- Frame with N spikes, handshake at cycle 0:
  - ARM at cycle 1;
  - `spk_addr` valid at cycles 2..N+1;
  - ACTIV at N+2, FIRE at N+3, CAPT at N+4;
  - `out_valid` from N+5.
- Minimum frame period is N+6 cycles; `out_ready` low stalls indefinitely in OUT.
- A frame with all `FRAME_W` bits set takes `FRAME_W` ACCUM cycles. `spk_addr` reaches `FRAME_W-1` with no overflow.
- `in_ready` is low from ARM through OUT. No new frame can overlap an undrained output.

## Structure
- Shared package `fc_pkg` holds:
  - the state enum `sched_state_t`;
  - the `FRAME_W`/`AW` derivation helpers.
- Sub-module `spk_prio_enc`: combinational lowest-set-bit encoder over `FRAME_W` bits, producing `idx` (`AW` bits) and `any`.
  - It is instantiated once.
  - The mask clear (`mask & ~(1<<idx)`) is done in `fc_spk_sched`.

## Test plan
- Reset mid-ACCUM: assert `rst` low while `spk_addr` is streaming, then release.
  - Required: all outputs at their reset values, `in_ready=1`, `ts_cnt=0`.
- Frame `in_spk=0` with `NUM_TIME_STEPS=3`:
  - `en_accum` at cycle 1, `en_activ` at cycle 2, no `spk_addr` cycles;
  - `out_valid` at cycle 5 with `out_spk` equal to `nc_spk` sampled in CAPT;
  - `frame_spk_cnt=0`.
- Frame with bits {55, 3, 17}:
  - `spk_addr` = 3, 17, 55 on cycles 2, 3, 4;
  - `en_activ` at cycle 5;
  - `frame_spk_cnt=3`.
- All-ones frame (`FRAME_W=56`): 56 consecutive ascending addresses 0..55, then `en_activ`.
- Three frames with `NUM_TIME_STEPS=3`:
  - `last_time_step` and `out_last` are high only for the third frame;
  - the fourth frame again has `last_time_step=0` (wrap).
- Backpressure: hold `out_ready=0` for 10 cycles.
  - Required: `out_spk` stable, `in_ready=0`, no `en_accum` pulse;
  - the next frame is accepted only after the handshake.
